// File: rtl/dual_issue_if.sv
// Fetch-to-issue bundle for dual_issue_buffer.
// Fetch side: fetch_valid/fetch_inst0/fetch_inst1/fetch_pc in, fetch_ready out.
// Control:    flush, issue_ready, x_load_valid/x_load_rd (load now in execute slot 1).
// Issue side: slot1_* (older) and slot2_* (younger) valid/inst/pc out.
// master = fetch + execute stages, slave = the buffer.
interface dual_issue_if;
    logic        fetch_valid;
    logic [31:0] fetch_inst0;
    logic [31:0] fetch_inst1;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        issue_ready;
    logic        x_load_valid;
    logic [4:0]  x_load_rd;
    logic        slot1_valid;
    logic [31:0] slot1_inst;
    logic [31:0] slot1_pc;
    logic        slot2_valid;
    logic [31:0] slot2_inst;
    logic [31:0] slot2_pc;

    modport master (
        output fetch_valid, fetch_inst0, fetch_inst1, fetch_pc,
        output flush, issue_ready, x_load_valid, x_load_rd,
        input  fetch_ready,
        input  slot1_valid, slot1_inst, slot1_pc,
        input  slot2_valid, slot2_inst, slot2_pc
    );

    modport slave (
        input  fetch_valid, fetch_inst0, fetch_inst1, fetch_pc,
        input  flush, issue_ready, x_load_valid, x_load_rd,
        output fetch_ready,
        output slot1_valid, slot1_inst, slot1_pc,
        output slot2_valid, slot2_inst, slot2_pc
    );
endinterface

// File: rtl/dual_issue_buffer.sv
// Circular instruction buffer between fetch and the execute pipeline register.
// Accepts instruction pairs from fetch, presents up to two per cycle in program
// order, splitting pairs on control/memory/intra-pair load-use rules and
// withholding instructions blocked by the load currently in execute.
// Ports: clk, rst (async, active-high), bus (dual_issue_if.slave).
module dual_issue_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    dual_issue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    entry_t          ent_a;
    entry_t          ent_b;
    logic            a_blk;
    logic            b_blk;
    logic            pair_hazard;
    logic            s1v;
    logic            s2v;
    logic            push;
    logic [1:0]      pops;

    function automatic logic is_mem(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    endfunction

    // True when an instruction actually reads register r as a source.
    function automatic logic reads_reg(input logic [6:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] r);
        return (uses_rs1(op) && (rs1 == r)) || (uses_rs2(op) && (rs2 == r));
    endfunction

    // Candidate selection and hazard evaluation.
    always_comb begin
        ent_a = mem_q[head_q];
        ent_b = mem_q[head_q + PW'(1)];

        a_blk = bus.x_load_valid && (bus.x_load_rd != 5'd0) &&
                reads_reg(ent_a.inst[6:0], ent_a.inst[19:15], ent_a.inst[24:20], bus.x_load_rd);
        b_blk = bus.x_load_valid && (bus.x_load_rd != 5'd0) &&
                reads_reg(ent_b.inst[6:0], ent_b.inst[19:15], ent_b.inst[24:20], bus.x_load_rd);

        // Younger one cannot consume the older load's result in the same cycle.
        pair_hazard = (ent_a.inst[6:0] == 7'b0000011) && (ent_a.inst[11:7] != 5'd0) &&
                      reads_reg(ent_b.inst[6:0], ent_b.inst[19:15], ent_b.inst[24:20],
                                ent_a.inst[11:7]);

        s1v = (count_q >= CW'(1)) && !a_blk;
        s2v = s1v && (count_q >= CW'(2)) &&
              !is_ctrl(ent_a.inst[6:0]) &&
              !(is_mem(ent_a.inst[6:0]) && is_mem(ent_b.inst[6:0])) &&
              !pair_hazard && !b_blk;

        push = bus.fetch_valid && bus.fetch_ready;
        pops = bus.issue_ready ? (2'(s1v) + 2'(s2v)) : 2'd0;
    end

    // Ready from registered count only: room for a full pair.
    assign bus.fetch_ready = (count_q <= CW'(DEPTH - 2));

    assign bus.slot1_valid = s1v;
    assign bus.slot1_inst  = s1v ? ent_a.inst : NOP;
    assign bus.slot1_pc    = s1v ? ent_a.pc   : 32'd0;
    assign bus.slot2_valid = s2v;
    assign bus.slot2_inst  = s2v ? ent_b.inst : NOP;
    assign bus.slot2_pc    = s2v ? ent_b.pc   : 32'd0;

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pops);
            tail_q  <= push ? tail_q + PW'(2) : tail_q;
            count_q <= count_q + (push ? CW'(2) : CW'(0)) - CW'(pops);
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_q[tail_q]          <= '{inst: bus.fetch_inst0, pc: bus.fetch_pc};
            mem_q[tail_q + PW'(1)] <= '{inst: bus.fetch_inst1, pc: bus.fetch_pc + 32'd4};
        end
    end
endmodule
